uart_rx_core: RTL and testbench
===============================

# uart_rx_core

Parametrised UART receive core; successor to the fixed 8-bit receiver. It samples an asynchronous serial line at 16x oversampling with 3-sample majority voting. Data width, parity mode and stop-bit count are configurable. Each received frame is delivered through a valid/ready handshake, with per-frame parity and framing status and overrun reporting. The core sits between the pad-side `rxd` input and the host-side register or FIFO logic.

## Interface
- `CLK_FREQ_HZ`, 50_000_000: `sys_clk` frequency.
- `BAUD`, 115200: line rate.
- `DATA_BITS`, 8: payload bits per frame. Legal range 5..9.
- `PARITY`, 0: parity mode. 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: stop bits per frame. Legal values 1 or 2.
- `sys_clk  in  1`: single clock. All logic is on the rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `rxd  in  1`: asynchronous serial input. Idle high.
- `rx_data  out  DATA_BITS`: received payload, LSB = first bit on the wire.
- `rx_valid  out  1`: `rx_data` and the status flags are valid.
- `rx_ready  in  1`: consumer accepts the frame when `rx_valid && rx_ready` at a clock edge.
- `parity_err  out  1`: parity mismatch for the held frame. Always 0 when `PARITY` = 0.
- `frame_err  out  1`: at least one stop bit was sampled low for the held frame.
- `overrun  out  1`: one-cycle pulse when a completed frame is dropped.
- `busy  out  1`: high whenever the FSM is not in IDLE.
- `break_det  out  1`: present only with `UART_RX_BREAK_DET_EN`.

## Operation
- **Input synchronisation:** `rxd` passes through a 2-flop synchroniser. Both flops reset to 1.
- **Oversample tick:** one-cycle tick every `DIV = max(1, CLK_FREQ_HZ / (BAUD*16))` cycles (integer division). The divisor counter restarts at 0 when the FSM leaves IDLE.
- **Bit sampling:** a 4-bit tick counter runs within each bit. The bit value is the majority of the samples at ticks 7, 8 and 9.
- **IDLE:** move to START on a high-to-low transition of the synchronised line.
- **START:**
  - If the majority sample is 0, go to DATA.
  - If it is 1, treat it as a false start and return to IDLE. Nothing is delivered.
- **DATA:** shift in `DATA_BITS` samples, LSB first. Then go to PARITY if `PARITY` != 0, otherwise to STOP.
- **PARITY:**
  - Even mode: error if XOR(data, parity bit) = 1.
  - Odd mode: error if XOR(data, parity bit) = 0.
- **STOP:**
  - Sample each stop bit. Any low sample sets `frame_err`.
  - After the tick-9 sample of the last stop bit, commit the frame and return to IDLE. The FSM does not wait for the end of the stop bit, so it can resync early.
- **Commit with output free** (`!rx_valid`, or `rx_ready` high in the same cycle):
  - load `rx_data`, `parity_err` and `frame_err`;
  - set `rx_valid`.
- **Commit while a frame is held** (`rx_valid && !rx_ready`):
  - the new frame is discarded;
  - the held frame and its flags are unchanged;
  - `overrun` pulses high for 1 cycle.
- **Accept:** `rx_valid` clears on an accept edge unless a commit happens in the same cycle.
- **Flag lifetime:** `parity_err` and `frame_err` are meaningful only while `rx_valid` is high. They update only on a commit.
- **Reset, at any time including mid-frame:** FSM to IDLE, all counters to 0, synchroniser to 1. All outputs go to 0: `rx_data`, `rx_valid`, flags, `overrun`, `busy`, `break_det`. A partial frame is lost.

## Timing
- Synchroniser latency is 2 cycles from an `rxd` edge to the FSM seeing it.
- `busy` rises 1 cycle after the synchronised falling edge is seen.
- A frame has `N = 1 + DATA_BITS + (PARITY != 0) + STOP_BITS` bits.
- `rx_valid` rises 1 cycle after the tick that takes the final stop-bit sample. That is ((N−1)·16 + 10)·DIV cycles, ±1 cycle, after the FSM leaves IDLE.
- `busy` falls in the same cycle `rx_valid` rises.
- A start edge arriving in the cycle after the commit is detected normally.
- Error tolerance: at least ±3% baud mismatch for 8N1.

## Configuration
- **`UART_RX_BREAK_DET_EN` defined:**
  - A frame with start, all data, parity (if any) and all stop samples equal to 0 does not commit.
  - Instead `break_det` pulses for 1 cycle and the FSM enters BREAK.
  - BREAK holds `busy` high until the synchronised line returns to 1, then goes to IDLE.
- **Undefined:**
  - The `break_det` port and the BREAK state are absent.
  - An all-zero frame commits as data 0 with `frame_err` = 1.

## Structure
- **Package `uart_pkg`:**
  - parity mode constants (NONE/EVEN/ODD);
  - FSM state enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - oversample constant 16;
  - constant function `baud_div(clk_hz, baud)`.
- **Sub-module `uart_baud_tick`:** divisor counter with synchronous restart, producing the oversample tick. The FSM, shift register and output stage stay in `uart_rx_core`.

## Test plan
Bench parameters: `CLK_FREQ_HZ` = 1_843_200 and `BAUD` = 115200 (so `DIV` = 1) unless noted.
1. 8N1, send 0xA5 with `rx_ready` held high -> `rx_data` = 0xA5, single `rx_valid` cycle, `parity_err` = `frame_err` = 0, `busy` low afterwards.
2. `DATA_BITS` = 7, even parity, send 0x55 with the parity bit inverted -> `rx_data` = 0x55, `parity_err` = 1. Odd mode with the correct bit -> `parity_err` = 0.
3. 8N2, send 0x3C with the second stop bit low -> `frame_err` = 1 and `rx_data` = 0x3C.
4. 4-cycle low glitch on idle `rxd` -> no `rx_valid`, `busy` returns to 0 in the middle of the START bit.
5. Send 0x11 then 0x22 with `rx_ready` = 0 -> `overrun` pulses once, `rx_data` stays 0x11. Then raise `rx_ready` for 1 cycle -> `rx_valid` = 0.
6. Assert `rst` mid-DATA, release, send 0x7E -> all outputs 0 during reset, then a clean 0x7E is received. Build with `UART_RX_BREAK_DET_EN` and hold `rxd` low for 2 frame times -> one `break_det` pulse, no `rx_valid`.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive path.
//   - parity mode encodings (PAR_NONE / PAR_EVEN / PAR_ODD)
//   - receiver FSM state type
//   - oversampling ratio and the baud divisor helper
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  localparam int unsigned OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } rx_state_e;

  // System clocks per oversample tick, never below 1.
  function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
    int unsigned d;
    d = clk_hz / (baud * OVERSAMPLE);
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample tick generator.
// Ports:
//   i_clk     - system clock
//   i_rst     - synchronous active-high reset
//   i_restart - hold the divisor at 0 and suppress ticks while high
//   o_tick    - one-cycle pulse every DIV cycles while not restarting
module uart_baud_tick #(
  parameter int unsigned DIV = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_restart,
  output logic o_tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(DIV - 1));
  // Restart is held for the whole idle period, so the first tick after
  // leaving idle lands exactly DIV cycles later.
  assign o_tick = w_wrap && !i_restart;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_restart) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: parametrised UART receiver, 16x oversampling with 3-sample
// majority vote at ticks 7/8/9 of every bit.
// Ports:
//   sys_clk, rst          - clock, synchronous active-high reset
//   rxd                   - asynchronous serial input, idle high
//   rx_data/rx_valid      - received frame, held until rx_ready accepts it
//   rx_ready              - consumer accept
//   parity_err, frame_err - status of the held frame
//   overrun               - one-cycle pulse when a completed frame is dropped
//   busy                  - receiver not idle
//   break_det             - one-cycle pulse on an all-zero frame; exists only
//                           when UART_RX_BREAK_DET_EN is defined
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY      = 0,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
`ifdef UART_RX_BREAK_DET_EN
  output logic                 break_det,
`endif
  output logic                 busy
);

  localparam int unsigned DIV       = baud_div(CLK_FREQ_HZ, BAUD);
  localparam logic [3:0]  LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]  LAST_STOP = 4'(STOP_BITS - 1);

  // Synchroniser and edge detect
  logic r_sync1, r_sync2, r_line_prev;
  logic w_fall;

  // Sequencing
  rx_state_e r_state, w_state_d;
  logic       w_tick;
  logic [3:0] r_tick_cnt;
  logic [3:0] r_bit_cnt;
  logic       w_mid;
  logic       w_end;

  // Sampling
  logic r_s7, r_s8;
  logic w_maj;

  // Frame under reception
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_err;
  logic                 r_frm_err;
  logic                 w_par_x;
  logic                 w_commit;

  // Output stage
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_parity_err;
  logic                 r_frame_err;
  logic                 r_overrun;

`ifdef UART_RX_BREAK_DET_EN
  logic r_all_zero;
  logic r_break_det;
  logic w_break;
`endif

  uart_baud_tick #(
    .DIV(DIV)
  ) u_baud_tick (
    .i_clk    (sys_clk),
    .i_rst    (rst),
    .i_restart(r_state == StIdle),
    .o_tick   (w_tick)
  );

  assign w_fall = r_line_prev && !r_sync2;
  assign w_mid  = w_tick && (r_tick_cnt == 4'd9);
  assign w_end  = w_tick && (r_tick_cnt == 4'd15);
  // Third vote is the live line at tick 9, so the decision is ready on that tick.
  assign w_maj  = (r_s7 & r_s8) | (r_s7 & r_sync2) | (r_s8 & r_sync2);
  assign w_par_x = (^r_shift) ^ w_maj;

  //--------------------------------------------------------------------------
  // FSM
  //--------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_commit  = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    w_break   = 1'b0;
`endif
    case (r_state)
      StIdle: begin
        if (w_fall) w_state_d = StStart;
      end
      StStart: begin
        if (w_mid && w_maj) begin
          w_state_d = StIdle;          // false start
        end else if (w_end) begin
          w_state_d = StData;
        end
      end
      StData: begin
        if (w_end && (r_bit_cnt == LAST_DATA)) begin
          w_state_d = (PARITY != PAR_NONE) ? StParity : StStop;
        end
      end
      StParity: begin
        if (w_end) w_state_d = StStop;
      end
      StStop: begin
        // Finish at the tick-9 sample of the last stop bit to allow early resync.
        if (w_mid && (r_bit_cnt == LAST_STOP)) begin
`ifdef UART_RX_BREAK_DET_EN
          if (r_all_zero && !w_maj) begin
            w_break   = 1'b1;
            w_state_d = StBreak;
          end else begin
            w_commit  = 1'b1;
            w_state_d = StIdle;
          end
`else
          w_commit  = 1'b1;
          w_state_d = StIdle;
`endif
        end
      end
`ifdef UART_RX_BREAK_DET_EN
      StBreak: begin
        if (r_sync2) w_state_d = StIdle;
      end
`endif
      default: w_state_d = StIdle;
    endcase
  end

  //--------------------------------------------------------------------------
  // Synchroniser, counters and samples
  //--------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_line_prev <= 1'b1;
      r_tick_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_s7        <= 1'b0;
      r_s8        <= 1'b0;
    end else begin
      r_sync1     <= rxd;
      r_sync2     <= r_sync1;
      r_line_prev <= r_sync2;

      if (r_state == StIdle) begin
        r_tick_cnt <= '0;
      end else if (w_tick) begin
        r_tick_cnt <= r_tick_cnt + 4'd1;
      end

      // Bit index is per state; it only advances within DATA and STOP.
      if (r_state != w_state_d) begin
        r_bit_cnt <= '0;
      end else if (w_end) begin
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end

      if (w_tick && (r_tick_cnt == 4'd7)) r_s7 <= r_sync2;
      if (w_tick && (r_tick_cnt == 4'd8)) r_s8 <= r_sync2;
    end
  end

  //--------------------------------------------------------------------------
  // Frame datapath
  //--------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_shift   <= '0;
      r_par_err <= 1'b0;
      r_frm_err <= 1'b0;
    end else begin
      if (r_state == StIdle) begin
        r_par_err <= 1'b0;
        r_frm_err <= 1'b0;
      end else if (w_mid) begin
        case (r_state)
          StData:   r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
          StParity: r_par_err <= (PARITY == PAR_ODD) ? !w_par_x : w_par_x;
          StStop:   if (!w_maj) r_frm_err <= 1'b1;
          default:  ;
        endcase
      end
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_all_zero  <= 1'b0;
      r_break_det <= 1'b0;
    end else begin
      r_break_det <= w_break;
      if (r_state == StIdle) begin
        r_all_zero <= 1'b1;
      end else if (w_mid && (r_state inside {StData, StParity, StStop})) begin
        r_all_zero <= r_all_zero & !w_maj;
      end
    end
  end

  assign break_det = r_break_det;
`endif

  //--------------------------------------------------------------------------
  // Output stage
  //--------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_commit) begin
        if (!r_rx_valid || rx_ready) begin
          r_rx_data    <= r_shift;
          r_parity_err <= r_par_err;
          // Final stop sample is not yet folded into r_frm_err.
          r_frame_err  <= r_frm_err | !w_maj;
          r_rx_valid   <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;
  assign busy       = (r_state != StIdle);

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: four receivers in different frame formats (8N1, 7E1, 7O2, 8N2)
// at DIV = 1. Stimulus pushes the expected frame into a scoreboard queue; a
// monitor pops and compares on every accepted rx_valid.
module tb_uart_rx_core;

  localparam int unsigned CLK_HZ  = 1_843_200;
  localparam int unsigned BAUD_R  = 115200;
  localparam int          BIT_CYC = 16;
  localparam int          NL      = 4;
  localparam int DB [NL] = '{8, 7, 7, 8};
  localparam int PM [NL] = '{0, 1, 2, 0};
  localparam int SB [NL] = '{1, 1, 2, 2};

  typedef struct {
    int         lane;
    logic [8:0] data;
    bit         perr;
    bit         ferr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd  [NL];
  logic       rdy  [NL];
  logic [8:0] dat  [NL];
  logic       vld  [NL];
  logic       perr [NL];
  logic       ferr [NL];
  logic       ovr  [NL];
  logic       bsy  [NL];
  logic [7:0] d0, d3;
  logic [6:0] d1, d2;
`ifdef UART_RX_BREAK_DET_EN
  logic       brk  [NL];
  int         brk_cnt [NL];
`endif

  exp_t q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ovr_cnt [NL];

  always #5 clk = ~clk;

  assign dat[0] = {1'b0, d0};
  assign dat[1] = {2'b0, d1};
  assign dat[2] = {2'b0, d2};
  assign dat[3] = {1'b0, d3};

  uart_rx_core #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD_R), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
  u_l0 (
    .sys_clk(clk), .rst(rst), .rxd(rxd[0]), .rx_data(d0), .rx_valid(vld[0]),
    .rx_ready(rdy[0]), .parity_err(perr[0]), .frame_err(ferr[0]), .overrun(ovr[0]),
`ifdef UART_RX_BREAK_DET_EN
    .break_det(brk[0]),
`endif
    .busy(bsy[0])
  );

  uart_rx_core #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD_R), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1))
  u_l1 (
    .sys_clk(clk), .rst(rst), .rxd(rxd[1]), .rx_data(d1), .rx_valid(vld[1]),
    .rx_ready(rdy[1]), .parity_err(perr[1]), .frame_err(ferr[1]), .overrun(ovr[1]),
`ifdef UART_RX_BREAK_DET_EN
    .break_det(brk[1]),
`endif
    .busy(bsy[1])
  );

  uart_rx_core #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD_R), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2))
  u_l2 (
    .sys_clk(clk), .rst(rst), .rxd(rxd[2]), .rx_data(d2), .rx_valid(vld[2]),
    .rx_ready(rdy[2]), .parity_err(perr[2]), .frame_err(ferr[2]), .overrun(ovr[2]),
`ifdef UART_RX_BREAK_DET_EN
    .break_det(brk[2]),
`endif
    .busy(bsy[2])
  );

  uart_rx_core #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD_R), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2))
  u_l3 (
    .sys_clk(clk), .rst(rst), .rxd(rxd[3]), .rx_data(d3), .rx_valid(vld[3]),
    .rx_ready(rdy[3]), .parity_err(perr[3]), .frame_err(ferr[3]), .overrun(ovr[3]),
`ifdef UART_RX_BREAK_DET_EN
    .break_det(brk[3]),
`endif
    .busy(bsy[3])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Builds the wire image of one frame, predicts the result, then drives it.
  task automatic send_frame(input int l, input logic [8:0] data, input bit flip,
                            input bit [1:0] stops, input bit expect_drop);
    logic       b[$];
    exp_t       e;
    logic [8:0] d;
    bit         pbit;
    bit         x;
    bit         all0;
    bit         commit;
    d    = data & 9'((1 << DB[l]) - 1);
    pbit = 1'b0;
    b.push_back(1'b0);
    for (int i = 0; i < DB[l]; i++) b.push_back(d[i]);
    if (PM[l] != 0) begin
      pbit = ((PM[l] == 1) ? ^d : ~^d) ^ flip;
      b.push_back(pbit);
    end
    for (int i = 0; i < SB[l]; i++) b.push_back(stops[i]);

    e.lane = l;
    e.data = d;
    x      = (^d) ^ pbit;
    e.perr = (PM[l] == 0) ? 1'b0 : ((PM[l] == 1) ? x : !x);
    e.ferr = 1'b0;
    for (int i = 0; i < SB[l]; i++) if (!stops[i]) e.ferr = 1'b1;
    all0 = 1'b1;
    foreach (b[i]) if (b[i]) all0 = 1'b0;
    commit = !expect_drop;
`ifdef UART_RX_BREAK_DET_EN
    if (all0) commit = 1'b0;
`else
    if (all0) e.ferr = 1'b1;
`endif
    if (commit) q.push_back(e);

    foreach (b[i]) begin
      rxd[l] = b[i];
      cycles(BIT_CYC);
    end
    rxd[l] = 1'b1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      for (int l = 0; l < NL; l++) begin
        if (ovr[l]) ovr_cnt[l]++;
`ifdef UART_RX_BREAK_DET_EN
        if (brk[l]) brk_cnt[l]++;
`endif
        if (vld[l] && rdy[l]) begin
          if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_valid lane %0d: got data 0x%0h, expected no frame",
                     l, dat[l]);
          end else begin
            mon_e = q.pop_front();
            check("lane", l, mon_e.lane);
            check("rx_data", dat[l], mon_e.data);
            check("parity_err", perr[l], mon_e.perr);
            check("frame_err", ferr[l], mon_e.ferr);
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int ovc;
    int len;
    bit seen;
    rst = 1'b1;
    for (int l = 0; l < NL; l++) begin
      rxd[l]     = 1'b1;
      rdy[l]     = 1'b1;
      ovr_cnt[l] = 0;
`ifdef UART_RX_BREAK_DET_EN
      brk_cnt[l] = 0;
`endif
    end
    cycles(4);
    for (int l = 0; l < NL; l++) begin
      check("reset_rx_data", dat[l], 0);
      check("reset_rx_valid", vld[l], 0);
      check("reset_busy", bsy[l], 0);
      check("reset_flags", {perr[l], ferr[l], ovr[l]}, 0);
    end
    rst = 1'b0;
    cycles(5);

    // 8N1 0xA5
    send_frame(0, 9'hA5, 1'b0, 2'b11, 1'b0);
    cycles(20);
    check("t1_busy_after", bsy[0], 0);
    check("t1_valid_after", vld[0], 0);

    // parity: 7E1 bad parity, 7O2 good parity, and the converse
    send_frame(1, 9'h55, 1'b1, 2'b11, 1'b0);
    cycles(10);
    send_frame(2, 9'h55, 1'b0, 2'b11, 1'b0);
    cycles(10);
    send_frame(1, 9'h2A, 1'b0, 2'b11, 1'b0);
    cycles(10);
    send_frame(2, 9'h2A, 1'b1, 2'b11, 1'b0);
    cycles(10);

    // 8N2 with second stop low
    send_frame(3, 9'h3C, 1'b0, 2'b01, 1'b0);
    cycles(20);

    // 4-cycle glitch
    rxd[0] = 1'b0;
    cycles(4);
    rxd[0] = 1'b1;
    seen = 1'b0;
    len  = 0;
    for (int i = 0; i < 40; i++) begin
      cycles(1);
      if (bsy[0]) begin
        seen = 1'b1;
        len++;
      end
    end
    check("glitch_busy_seen", seen, 1);
    check("glitch_busy_short", (len >= 5 && len <= 14), 1);
    check("glitch_busy_end", bsy[0], 0);
    check("glitch_no_valid", vld[0], 0);

    // overrun
    rdy[0] = 1'b0;
    ovc    = ovr_cnt[0];
    send_frame(0, 9'h11, 1'b0, 2'b11, 1'b0);
    cycles(10);
    send_frame(0, 9'h22, 1'b0, 2'b11, 1'b1);
    cycles(10);
    check("ovr_pulses", ovr_cnt[0] - ovc, 1);
    check("ovr_held_data", dat[0], 9'h11);
    check("ovr_held_valid", vld[0], 1);
    rdy[0] = 1'b1;
    cycles(1);
    rdy[0] = 1'b0;
    check("ovr_valid_cleared", vld[0], 0);
    rdy[0] = 1'b1;
    cycles(5);

    // reset mid-DATA with a frame held
    rdy[0] = 1'b0;
    send_frame(0, 9'h5A, 1'b0, 2'b11, 1'b0);
    cycles(5);
    rxd[0] = 1'b0;
    cycles(BIT_CYC);
    rxd[0] = 1'b0;
    cycles(BIT_CYC);
    rxd[0] = 1'b1;
    cycles(BIT_CYC);
    check("prerst_busy", bsy[0], 1);
    check("prerst_valid", vld[0], 1);
    rst = 1'b1;
    cycles(2);
    check("rst_rx_data", dat[0], 0);
    check("rst_rx_valid", vld[0], 0);
    check("rst_busy", bsy[0], 0);
    check("rst_flags", {perr[0], ferr[0], ovr[0]}, 0);
    q.delete();
    rxd[0] = 1'b1;
    rdy[0] = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(5);
    send_frame(0, 9'h7E, 1'b0, 2'b11, 1'b0);
    cycles(20);

`ifdef UART_RX_BREAK_DET_EN
    begin
      int bc;
      bc     = brk_cnt[0];
      rxd[0] = 1'b0;
      cycles(2 * 10 * BIT_CYC);
      check("break_busy_while_low", bsy[0], 1);
      rxd[0] = 1'b1;
      cycles(20);
      check("break_pulses", brk_cnt[0] - bc, 1);
      check("break_busy_after", bsy[0], 0);
      check("break_no_valid", vld[0], 0);
    end
`else
    send_frame(0, 9'h00, 1'b0, 2'b00, 1'b0);
    cycles(20);
`endif

    // randomized frames on all lanes
    for (int n = 0; n < 60; n++) begin
      int         l;
      logic [8:0] dv;
      bit [1:0]   st;
      l     = $urandom_range(0, NL - 1);
      dv    = 9'($urandom);
      st[0] = ($urandom_range(0, 5) != 0);
      st[1] = ($urandom_range(0, 5) != 0);
      send_frame(l, dv, 1'($urandom_range(0, 1)), st, 1'b0);
      cycles($urandom_range(5, 30));
    end

    for (int i = 0; i < 200 && q.size() != 0; i++) cycles(1);
    check("drain_queue_empty", q.size(), 0);
    for (int l = 0; l < NL; l++) check("final_busy", bsy[l], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
